// File: rtl/multicycle_addsub_if.sv
// Request/response bundle for the multi-cycle adder/subtractor.
// The master issues start/sub/a/b and the slave returns status, result and flags.
interface multicycle_addsub_if #(parameter int WIDTH = 64);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/multicycle_addsub.sv
// Two's-complement add/sub that reuses one CHUNK-bit adder slice over WIDTH/CHUNK cycles.
// state | meaning
// IDLE  | waiting for start; result/flags hold the last answer
// RUN   | one chunk per edge, LSB chunk first, carry kept in a register
// DONE  | one-cycle done pulse; start here launches the next operation
module multicycle_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_addsub_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, last, busy_c, done_c;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic             flag_n, flag_z, flag_c, flag_v;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             cout;
  logic [WIDTH-1:0] res_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last = (cnt == CW'(NCH - 1));

  // One adder slice; the partial result is merged so the final-edge Z flag sees the whole word.
  always_comb begin
    base    = 32'(cnt) * 32'(CHUNK);
    a_sl    = a_q[base +: CHUNK];
    b_sl    = b_q[base +: CHUNK];
    {cout, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    res_nxt = result;
    res_nxt[base +: CHUNK] = s_sl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub;
      cnt    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      result <= res_nxt;
      carry  <= cout;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        flag_c <= cout;
        // carry into the MSB is recovered from the MSB sum bit
        flag_v <= a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1] ^ cout;
        flag_n <= res_nxt[WIDTH-1];
        flag_z <= (res_nxt == '0);
      end
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result;
  assign bus.flag_n = flag_n;
  assign bus.flag_z = flag_z;
  assign bus.flag_c = flag_c;
  assign bus.flag_v = flag_v;
endmodule
